mig_phrase_port: RTL and testbench
==================================

# mig_phrase_port

Sits between the 128-bit phrase streams and the DDR3 MIG user interface (UI). Write side: consumes phrases (with frame-start tuser) and issues MIG write commands to a linear frame buffer. Read side: continuously prefetches the same frame buffer and emits phrases with frame-start tuser to the pixel-unpacking stage. Arbitrates both directions onto the single MIG command port, with credit-based flow control on read returns, because MIG read data has no backpressure.

## Interface
Parameters:
- FRAME_PHRASES, 7200: phrases per frame; address index wraps at this count.
- ADDR_INCR, 8: MIG address step per phrase (128 bits = BL8 on x16).
- RD_DEPTH, 16: read-return FIFO depth (power of 2).

Ports:
- clk_in  in  1  UI clock (ui_clk)
- rst_n_in  in  1  reset, asynchronous, active-low
- calib_done_in  in  1  MIG init_calib_complete; no commands issued while low
- wr_valid_in / wr_ready_in  in/out  1  write phrase handshake
- wr_data_in  in  128  write phrase
- wr_tuser_in  in  1  phrase is first of frame
- rd_valid_out / rd_ready_out  out/in  1  read phrase handshake
- rd_data_out  out  128  read phrase
- rd_tuser_out  out  1  phrase is frame index 0
- app_addr  out  27  MIG address
- app_cmd  out  3  000 write, 001 read
- app_en  out  1, app_rdy  in  1  command handshake
- app_wdf_data  out  128, app_wdf_wren  out  1, app_wdf_end  out  1, app_wdf_mask  out  16, app_wdf_rdy  in  1
- app_rd_data  in  128, app_rd_data_valid  in  1

## Operation
- States: ARB, WR, RD. Reset → ARB.
- Pending: wr_pend = wr_valid_in; rd_pend = credits > 0. Both gated by calib_done_in.
- credits = RD_DEPTH − fifo_count − outstanding. outstanding increments on accepted read command, decrements on app_rd_data_valid; simultaneous inc/dec nets zero.
- ARB: if only one pending, grant it. If both are pending, grant opposite of last_grant (round-robin). Write grant: wr_ready_in high combinationally that cycle; phrase and address latched; → WR. Read grant: latch rd address; → RD.
- WR: app_en=1, app_cmd=000, app_wdf_wren=app_wdf_end=1, app_wdf_mask=0. cmd_done sets on app_en&&app_rdy; data_done sets on wren&&app_wdf_rdy. Each strobe drops individually once its flag is set. → ARB when both are done (including the same cycle).
- RD: app_en=1, app_cmd=001 until app_rdy → ARB.
- Write index: phrase with wr_tuser_in is written at index 0, next index 1. Otherwise index+1, wrapping FRAME_PHRASES−1 → 0. app_addr = index × ADDR_INCR.
- Read index: 0..FRAME_PHRASES−1, wraps. A separate return counter tracks returned phrases; rd_tuser_out = (return index of FIFO head == 0). The tuser bit is stored in the FIFO alongside data.
- app_rd_data_valid always pushes into the FIFO. Credits guarantee no overflow. Overflow is an assertion failure in the bench.

## Timing
- Reset values: wr_ready_in 0, rd_valid_out 0, rd_tuser_out 0, app_en 0, app_wdf_wren 0, app_wdf_end 0, app_cmd 000, app_addr 0, indices 0, outstanding 0, last_grant = read (first contested grant goes to write).
- Write: phrase accepted at cycle N; app_en/app_wdf_wren presented at N+1. Minimum 2 cycles per write (ARB+WR).
- Read: command presented the cycle after grant. Read data appears on rd_*_out the cycle after app_rd_data_valid (FIFO registered). FIFO is first-word-fall-through.
- rd_data_out and rd_tuser_out stay stable while rd_valid_out && !rd_ready_out.
- calib_done_in falling mid-WR/RD: current command completes; no new grants.
- Reset mid-operation clears everything, including outstanding. MIG must be reset together with this block; stale returns are out of scope.

## Structure
- Package mig_pkg: MIG_CMD_WRITE, MIG_CMD_READ, state enum, PHRASE_W=128, MIG_ADDR_W=27.
- Sub-module phrase_fifo (129-bit wide, RD_DEPTH deep, FWFT, count output) for read returns.

## Test plan
- Calibration hold: calib_done_in=0 with wr_valid_in=1 → no app_en, wr_ready_in=0 for 100 cycles.
- Single write: tuser phrase 0xA5.. with app_rdy=app_wdf_rdy=1 → app_addr=0, app_cmd=000, one-cycle app_en+wren. Next phrase → app_addr=8.
- Split accept: app_wdf_rdy high 3 cycles before app_rdy → wren drops after accept, app_en held; WR exits only after app_rdy.
- Write wrap: FRAME_PHRASES=4, 5 phrases no tuser → addresses 0,8,16,24,0. Mid-frame tuser → address 0.
- Read credits: RD_DEPTH=4, rd_ready_out=0 → exactly 4 read commands, then none. Pop one → one more issued. rd_tuser_out=1 on return index 0 only.
- Contention: both pending continuously → commands alternate W,R,W,R; no FIFO overflow with random app_rdy.

Source files
------------

// File: rtl/mig_pkg.sv
// Shared types and constants for the phrase <-> MIG UI bridge.
package mig_pkg;
  localparam int PHRASE_W   = 128;
  localparam int MIG_ADDR_W = 27;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_ARB = 2'd0,
    ST_WR  = 2'd1,
    ST_RD  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_e;

  // One read-return FIFO entry: frame-start flag travels with its phrase.
  typedef struct packed {
    logic                tuser;
    logic [PHRASE_W-1:0] data;
  } rd_entry_t;

  // Phrase index to MIG byte-ish address (one BL8 burst per phrase).
  function automatic logic [MIG_ADDR_W-1:0] idx_to_addr(input int unsigned idx,
                                                       input int unsigned incr);
    int unsigned a;
    a = idx * incr;
    return a[MIG_ADDR_W-1:0];
  endfunction
endpackage

// File: rtl/mig_phrase_port_if.sv
// MIG user-interface bundle: command, write-data and read-return channels.
interface mig_phrase_port_if;
  import mig_pkg::*;

  logic [MIG_ADDR_W-1:0] app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_rdy;
  logic [PHRASE_W-1:0]   app_wdf_data;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic [PHRASE_W/8-1:0] app_wdf_mask;
  logic                  app_wdf_rdy;
  logic [PHRASE_W-1:0]   app_rd_data;
  logic                  app_rd_data_valid;

  // Controller side (this block).
  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  // Memory-controller side (MIG).
  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/mig_phrase_port_fifo.sv
// First-word-fall-through FIFO for MIG read returns; head is visible
// the cycle after a push and stays put until popped.
module phrase_fifo #(
  parameter int W     = 129,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Pointer/occupancy update; pushes into a full FIFO are dropped.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; no reset needed, reads are qualified by count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/mig_phrase_port.sv
// Bridges write/read phrase streams onto one MIG UI command port with
// round-robin arbitration and credit-limited read prefetch.
module mig_phrase_port
  import mig_pkg::*;
#(
  parameter int FRAME_PHRASES = 7200,
  parameter int ADDR_INCR     = 8,
  parameter int RD_DEPTH      = 16
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                calib_done_in,
  input  logic                wr_valid_in,
  output logic                wr_ready_in,
  input  logic [PHRASE_W-1:0] wr_data_in,
  input  logic                wr_tuser_in,
  output logic                rd_valid_out,
  input  logic                rd_ready_out,
  output logic [PHRASE_W-1:0] rd_data_out,
  output logic                rd_tuser_out,
  mig_phrase_port_if.master   mig
);
  localparam int IW = (FRAME_PHRASES > 1) ? $clog2(FRAME_PHRASES) : 1;
  localparam int CW = $clog2(RD_DEPTH) + 1;

  state_e                state_q, state_d;
  grant_e                last_q, last_d;
  logic [IW-1:0]         wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, ret_idx_q, ret_idx_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic                  cmd_done_q, cmd_done_d, data_done_q, data_done_d;
  logic [PHRASE_W-1:0]   wdata_q, wdata_d;
  logic [MIG_ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]            cmd_q, cmd_d;
  logic                  en_q, en_d, wren_q, wren_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_pop;
  rd_entry_t     fifo_din, fifo_head;
  logic          credits_ok, wr_pend, rd_pend, grant_wr, grant_rd;
  logic          cmd_fire, data_fire, rd_accept;
  logic [IW-1:0] wr_base;

  function automatic logic [IW-1:0] nxt_idx(input logic [IW-1:0] i);
    return (i == IW'(FRAME_PHRASES - 1)) ? '0 : i + IW'(1);
  endfunction

  // Arbitration, FSM next state and command/datapath next values.
  always_comb begin
    credits_ok = ({1'b0, fifo_count} + {1'b0, outst_q}) < (CW+1)'(RD_DEPTH);
    wr_pend    = calib_done_in && wr_valid_in;
    rd_pend    = calib_done_in && credits_ok;
    grant_wr   = (state_q == ST_ARB) && wr_pend && (!rd_pend || last_q == GNT_RD);
    grant_rd   = (state_q == ST_ARB) && rd_pend && !grant_wr;
    cmd_fire   = en_q && mig.app_rdy;
    data_fire  = wren_q && mig.app_wdf_rdy;
    rd_accept  = (state_q == ST_RD) && cmd_fire;
    wr_base    = wr_tuser_in ? '0 : wr_idx_q;

    state_d     = state_q;
    last_d      = last_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    cmd_d       = cmd_q;
    en_d        = en_q;
    wren_d      = wren_q;

    case (state_q)
      ST_ARB: begin
        if (grant_wr) begin
          state_d     = ST_WR;
          last_d      = GNT_WR;
          wdata_d     = wr_data_in;
          addr_d      = idx_to_addr(32'(wr_base), ADDR_INCR);
          wr_idx_d    = nxt_idx(wr_base);
          cmd_d       = MIG_CMD_WRITE;
          en_d        = 1'b1;
          wren_d      = 1'b1;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
        end else if (grant_rd) begin
          state_d  = ST_RD;
          last_d   = GNT_RD;
          addr_d   = idx_to_addr(32'(rd_idx_q), ADDR_INCR);
          rd_idx_d = nxt_idx(rd_idx_q);
          cmd_d    = MIG_CMD_READ;
          en_d     = 1'b1;
        end
      end
      ST_WR: begin
        // Command and data channels accept independently.
        cmd_done_d  = cmd_done_q | cmd_fire;
        data_done_d = data_done_q | data_fire;
        en_d        = !cmd_done_d;
        wren_d      = !data_done_d;
        if (cmd_done_d && data_done_d) state_d = ST_ARB;
      end
      ST_RD: begin
        if (cmd_fire) begin
          en_d    = 1'b0;
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase

    outst_d   = outst_q + CW'(rd_accept) - CW'(mig.app_rd_data_valid);
    ret_idx_d = mig.app_rd_data_valid ? nxt_idx(ret_idx_q) : ret_idx_q;
  end

  // State and registered MIG outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_ARB;
      last_q      <= GNT_RD;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      ret_idx_q   <= '0;
      outst_q     <= '0;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      cmd_q       <= MIG_CMD_WRITE;
      en_q        <= 1'b0;
      wren_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      ret_idx_q   <= ret_idx_d;
      outst_q     <= outst_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      cmd_q       <= cmd_d;
      en_q        <= en_d;
      wren_q      <= wren_d;
    end
  end

  assign wr_ready_in      = grant_wr;
  assign mig.app_addr     = addr_q;
  assign mig.app_cmd      = cmd_q;
  assign mig.app_en       = en_q;
  assign mig.app_wdf_data = wdata_q;
  assign mig.app_wdf_wren = wren_q;
  assign mig.app_wdf_end  = wren_q;
  assign mig.app_wdf_mask = '0;

  // Every return is pushed; credits keep the FIFO from overflowing.
  assign fifo_din.tuser = (ret_idx_q == '0);
  assign fifo_din.data  = mig.app_rd_data;
  assign fifo_pop       = rd_valid_out && rd_ready_out;

  phrase_fifo #(
    .W     ($bits(rd_entry_t)),
    .DEPTH (RD_DEPTH)
  ) u_rd_fifo (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .push  (mig.app_rd_data_valid),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rd_valid_out = !fifo_empty;
  assign rd_data_out  = rd_valid_out ? fifo_head.data : '0;
  assign rd_tuser_out = rd_valid_out && fifo_head.tuser;
endmodule

// File: tb/tb_mig_phrase_port.sv
// Directed bench for mig_phrase_port with a small MIG model and a
// frame-buffer/return-queue reference model checked every cycle.
module tb_mig_phrase_port;
  import mig_pkg::*;

  localparam int FP = 4;
  localparam int AI = 8;
  localparam int RD = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         calib = 1'b0;
  logic         wr_valid = 1'b0, wr_ready, wr_tuser = 1'b0;
  logic [127:0] wr_data = '0;
  logic         rd_valid, rd_ready = 1'b0, rd_tuser;
  logic [127:0] rd_data;

  mig_phrase_port_if ui();

  mig_phrase_port #(.FRAME_PHRASES(FP), .ADDR_INCR(AI), .RD_DEPTH(RD)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .calib_done_in(calib),
    .wr_valid_in(wr_valid), .wr_ready_in(wr_ready), .wr_data_in(wr_data), .wr_tuser_in(wr_tuser),
    .rd_valid_out(rd_valid), .rd_ready_out(rd_ready), .rd_data_out(rd_data), .rd_tuser_out(rd_tuser),
    .mig(ui)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [127:0] mem [FP];
  int           m_wr_idx = 0, m_rd_idx = 0, m_ret_cnt = 0, n_rd_cmds = 0;
  int           wq_addr[$], wq_daddr[$];
  logic [127:0] wq_data[$];
  int           rd_pend_q[$];
  logic [128:0] fq[$];
  int           wr_addr_log[$], rd_addr_log[$];
  bit           cmd_log[$];
  bit           log_cmds = 1'b0, rnd_mode = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, {127'b0, act}, {127'b0, exp});
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    chk(nm, 128'(act), 128'(exp));
  endtask

  // Compare process: outputs vs model, then model absorbs this cycle's handshakes.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chkb("rd_valid", rd_valid, fq.size() > 0);
        if (rd_valid && fq.size() > 0) begin
          chk("rd_data", rd_data, fq[0][127:0]);
          chkb("rd_tuser", rd_tuser, fq[0][128]);
        end
        if (ui.app_wdf_wren) begin
          chkb("wdf_end", ui.app_wdf_end, 1'b1);
          chk("wdf_mask", 128'(ui.app_wdf_mask), 128'd0);
        end
        if (ui.app_rd_data_valid) begin
          if (fq.size() >= RD) begin
            n_tests++; n_fail++;
            $display("FAIL fifo_overflow occupancy=%0d limit=%0d", fq.size(), RD);
          end
        end
        if (rd_valid && rd_ready && fq.size() > 0) void'(fq.pop_front());
        if (ui.app_rd_data_valid) begin
          fq.push_back({(m_ret_cnt % FP) == 0, ui.app_rd_data});
          m_ret_cnt++;
        end
        if (ui.app_en && ui.app_rdy) begin
          if (ui.app_cmd == MIG_CMD_READ) begin
            chki("rd_cmd_addr", int'(ui.app_addr), (m_rd_idx % FP) * AI);
            m_rd_idx++;
            n_rd_cmds++;
            rd_pend_q.push_back(int'(ui.app_addr));
            rd_addr_log.push_back(int'(ui.app_addr));
            if (log_cmds) cmd_log.push_back(1'b1);
          end else if (ui.app_cmd == MIG_CMD_WRITE && wq_addr.size() > 0) begin
            chki("wr_cmd_addr", int'(ui.app_addr), wq_addr[0]);
            wr_addr_log.push_back(int'(ui.app_addr));
            void'(wq_addr.pop_front());
            if (log_cmds) cmd_log.push_back(1'b0);
          end else begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_cmd cmd=%0d addr=%0d", ui.app_cmd, ui.app_addr);
          end
        end
        if (ui.app_wdf_wren && ui.app_wdf_rdy) begin
          if (wq_data.size() > 0) begin
            chk("wr_data", ui.app_wdf_data, wq_data[0]);
            mem[wq_daddr[0] / AI] = ui.app_wdf_data;
            void'(wq_data.pop_front());
            void'(wq_daddr.pop_front());
          end else begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_wdata act=%0h exp=none", ui.app_wdf_data);
          end
        end
        if (wr_valid && wr_ready) begin
          int base;
          base = wr_tuser ? 0 : m_wr_idx;
          wq_addr.push_back(base * AI);
          wq_daddr.push_back(base * AI);
          wq_data.push_back(wr_data);
          m_wr_idx = (base + 1) % FP;
        end
      end
    end
  end

  // MIG model: returns reads in order; randomises ready/latency in rnd_mode.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd_pend_q.size() > 0 && (!rnd_mode || $urandom_range(0, 1) == 1)) begin
        int a;
        a = rd_pend_q.pop_front();
        ui.app_rd_data_valid = 1'b1;
        ui.app_rd_data       = mem[a / AI];
      end else begin
        ui.app_rd_data_valid = 1'b0;
      end
      if (rnd_mode) begin
        ui.app_rdy     = ($urandom_range(0, 2) != 0);
        ui.app_wdf_rdy = ($urandom_range(0, 2) != 0);
        rd_ready       = ($urandom_range(0, 1) == 1);
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic t);
    bit got;
    got = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_tuser = t;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = wr_ready;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout act=no_accept exp=accept data=%0h", d);
    end
  endtask

  initial begin
    int first_w, last_w, n_w;
    int exp_wr[11];
    int exp_rd[5];
    exp_wr = '{0, 8, 16, 24, 0, 8, 16, 24, 0, 0, 8};
    exp_rd = '{0, 8, 16, 24, 0};
    ui.app_rdy = 1'b1;
    ui.app_wdf_rdy = 1'b1;
    ui.app_rd_data_valid = 1'b0;
    ui.app_rd_data = '0;
    for (int i = 0; i < FP; i++) mem[i] = {4{32'h1000_0000 + 32'(i)}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_wr_ready", wr_ready, 1'b0);
    chkb("rst_rd_valid", rd_valid, 1'b0);
    chkb("rst_rd_tuser", rd_tuser, 1'b0);
    chkb("rst_app_en", ui.app_en, 1'b0);
    chkb("rst_wren", ui.app_wdf_wren, 1'b0);
    chkb("rst_wend", ui.app_wdf_end, 1'b0);
    chki("rst_app_cmd", int'(ui.app_cmd), 0);
    chki("rst_app_addr", int'(ui.app_addr), 0);

    // Calibration hold
    rst_n = 1'b1;
    wr_valid = 1'b1;
    wr_data = {4{32'hDEAD_BEEF}};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chkb("calib_app_en", ui.app_en, 1'b0);
      chkb("calib_wr_ready", wr_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    calib = 1'b1;

    // Read credits: nothing consumed, so exactly RD reads go out
    repeat (40) @(posedge clk);
    #1;
    chki("credit_rd_cmds", n_rd_cmds, 4);
    chkb("credit_head_valid", rd_valid, 1'b1);
    chkb("credit_head_tuser", rd_tuser, 1'b1);
    chk("credit_head_data", rd_data, {4{32'h1000_0000}});
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chki("credit_rd_cmds_after_pop", n_rd_cmds, 5);
    chkb("credit_idx1_tuser", rd_tuser, 1'b0);
    chk("credit_idx1_data", rd_data, {4{32'h1000_0001}});
    for (int i = 0; i < 5; i++) chki("rd_addr_seq", rd_addr_log[i], exp_rd[i]);

    // Single writes (FIFO full, so read side is idle)
    send({4{32'hA5A5_A5A5}}, 1'b1);
    wr_valid = 1'b0;
    chkb("w1_app_en", ui.app_en, 1'b1);
    chkb("w1_wren", ui.app_wdf_wren, 1'b1);
    chki("w1_cmd", int'(ui.app_cmd), 0);
    chki("w1_addr", int'(ui.app_addr), 0);
    chk("w1_data", ui.app_wdf_data, {4{32'hA5A5_A5A5}});
    @(posedge clk);
    #1;
    chkb("w1_en_one_cycle", ui.app_en, 1'b0);
    chkb("w1_wren_one_cycle", ui.app_wdf_wren, 1'b0);
    send({4{32'h0000_0002}}, 1'b0);
    wr_valid = 1'b0;
    chki("w2_addr", int'(ui.app_addr), 8);
    @(posedge clk);
    #1;

    // Split accept: data channel ready for 3 cycles before command channel
    ui.app_rdy = 1'b0;
    send({4{32'h0000_0003}}, 1'b0);
    wr_valid = 1'b0;
    chkb("split_en", ui.app_en, 1'b1);
    chkb("split_wren", ui.app_wdf_wren, 1'b1);
    chki("split_addr", int'(ui.app_addr), 16);
    @(posedge clk);
    #1;
    wr_valid = 1'b1;
    wr_data  = {4{32'h0000_0004}};
    wr_tuser = 1'b0;
    chkb("split_wren_drop", ui.app_wdf_wren, 1'b0);
    chkb("split_en_held", ui.app_en, 1'b1);
    chkb("split_no_grant", wr_ready, 1'b0);
    @(posedge clk);
    #1;
    chkb("split_en_held2", ui.app_en, 1'b1);
    chkb("split_no_grant2", wr_ready, 1'b0);
    ui.app_rdy = 1'b1;
    @(posedge clk);
    #1;
    chkb("split_en_done", ui.app_en, 1'b0);
    chkb("split_back_in_arb", wr_ready, 1'b1);
    send({4{32'h0000_0004}}, 1'b0);

    // Wrap: 5 plain phrases, then a mid-frame tuser phrase and its successor
    for (int i = 0; i < 5; i++) send({4{32'h0000_0010 + 32'(i)}}, 1'b0);
    send({4{32'h0000_0020}}, 1'b1);
    send({4{32'h0000_0021}}, 1'b0);
    wr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chki("wr_log_len", wr_addr_log.size(), 11);
    for (int i = 0; i < 11 && i < wr_addr_log.size(); i++)
      chki("wr_addr_seq", wr_addr_log[i], exp_wr[i]);

    // Contention: both sides pending, grants must alternate
    rd_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    log_cmds = 1'b1;
    for (int i = 0; i < 6; i++) send({4{32'h0000_0100 + 32'(i)}}, 1'b0);
    wr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    log_cmds = 1'b0;
    first_w = -1;
    last_w  = -1;
    n_w     = 0;
    for (int i = 0; i < cmd_log.size(); i++) begin
      if (!cmd_log[i]) begin
        if (first_w < 0) first_w = i;
        last_w = i;
        n_w++;
      end
    end
    chki("contend_writes", n_w, 6);
    for (int i = (first_w < 0 ? 0 : first_w); i < last_w; i++)
      chkb("contend_alternate", cmd_log[i] != cmd_log[i+1], 1'b1);

    // Random MIG readiness and return latency
    rnd_mode = 1'b1;
    for (int i = 0; i < 10; i++) send({4{32'h0000_0200 + 32'(i)}}, i == 3);
    wr_valid = 1'b0;
    repeat (60) @(posedge clk);
    rnd_mode = 1'b0;
    #1;
    ui.app_rdy = 1'b1;
    ui.app_wdf_rdy = 1'b1;
    rd_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chki("writes_drained", wq_addr.size() + wq_data.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
